// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen
// Upstream command stage for the srff set/reset flop. Two raw, noisy request
// levels are synchronised, debounced and edge-detected. Each rising edge
// queues a command as a pending flag. An arbitration FSM turns the pending
// flags into clean, mutually exclusive, spaced s/r pulses.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   set_req  in   raw set request level (asynchronous to clk)
//   clr_req  in   raw clear request level (asynchronous to clk)
//   s        out  registered set pulse to the SR flop
//   r        out  registered reset pulse to the SR flop
//   busy     out  high whenever the FSM is not in IDLE
//   pend     out  registered pending flags {clr, set}
//   evt_cnt  out  [7:0] pulse event counter (only with SR_CMD_EVTCNT_EN)
//   evt_ovf  out  sticky wrap flag of evt_cnt (only with SR_CMD_EVTCNT_EN)
//
// Optional feature macro: SR_CMD_EVTCNT_EN adds evt_cnt/evt_ovf.

module sr_cmd_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int PULSE_LEN  = 1,
  parameter int HOLDOFF    = 2,
  parameter int SET_PRIO   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic [1:0] pend
`ifdef SR_CMD_EVTCNT_EN
  ,
  output logic [7:0] evt_cnt,
  output logic       evt_ovf
`endif
);

  localparam int DW   = $clog2(DEB_CYCLES) + 1;
  localparam int CMAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    HOLD
  } state_t;

  // Bit 0 is the set path, bit 1 the clear path, throughout.
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    debPrev_q;
  logic [DW-1:0] debCnt_q [2];
  logic [DW-1:0] debCnt_d [2];
  logic [1:0]    rise;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_q, s_d, r_q, r_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    consume;
  logic          issue;
  logic          pickSet;
  logic          pickAny;

  // Debounce: a level change is only accepted after the synchronised input
  // has differed from the debounced level for DEB_CYCLES consecutive cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i]    = deb_q[i];
      debCnt_d[i] = debCnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        debCnt_d[i] = '0;
      end else if (debCnt_q[i] == DEB_LAST) begin
        deb_d[i]    = sync2_q[i];
        debCnt_d[i] = '0;
      end else begin
        debCnt_d[i] = debCnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      debPrev_q <= '0;
      for (int i = 0; i < 2; i++) debCnt_q[i] <= '0;
    end else begin
      sync1_q   <= {clr_req, set_req};
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      debPrev_q <= deb_q;
      for (int i = 0; i < 2; i++) debCnt_q[i] <= debCnt_d[i];
    end
  end

  assign rise = deb_q & ~debPrev_q;

  // Selection among pending commands; SET_PRIO breaks the tie.
  assign pickAny = |pend_q;
  assign pickSet = pend_q[0] & ((SET_PRIO != 0) | ~pend_q[1]);

  // Arbitration FSM. Every path that starts a pulse goes through 'issue',
  // which consumes the chosen pend bit and raises exactly one of s/r, so
  // s and r can never be high together.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    r_d     = r_q;
    consume = '0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickAny) issue = 1'b1;
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          s_d = 1'b0;
          r_d = 1'b0;
          if (HOLDOFF > 0) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else if (pickAny) begin
            issue = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          if (pickAny) issue = 1'b1;
          else state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      state_d = PULSE;
      cnt_d   = '0;
      s_d     = pickSet;
      r_d     = ~pickSet;
      consume = pickSet ? 2'b01 : 2'b10;
    end
  end

  // A rise arriving on the edge its bit is consumed stays pending, so it
  // is not lost; a rise onto an already-set bit simply coalesces.
  assign pend_d = rise | (pend_q & ~consume);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      pend_q  <= pend_d;
    end
  end

  assign s    = s_q;
  assign r    = r_q;
  assign busy = (state_q != IDLE);
  assign pend = pend_q;

`ifdef SR_CMD_EVTCNT_EN
  logic [7:0] evtCnt_q;
  logic       evtOvf_q;

  // Counts pulse entries; wraps 255->0 and latches the wrap until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evtCnt_q <= '0;
      evtOvf_q <= 1'b0;
    end else if (issue) begin
      evtCnt_q <= evtCnt_q + 8'd1;
      if (evtCnt_q == 8'hFF) evtOvf_q <= 1'b1;
    end
  end

  assign evt_cnt = evtCnt_q;
  assign evt_ovf = evtOvf_q;
`endif

endmodule
